// File: rtl/sd_ser_pkg.sv
// sd_ser_pkg
//   Shared definitions for the sequence-detector serializer.
//   Holds the FSM state encoding and the helper that sizes the bit counter.
//   No ports; imported by sd_piso_serializer.
package sd_ser_pkg;

  // State codes are fixed so that the detector-side debug tools can decode them.
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_SHIFT  = 2'b01;
  localparam logic [1:0] S_PARITY = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SHIFT  = S_SHIFT,
    ST_PARITY = S_PARITY
  } state_t;

  // Counter width for "bits remaining" in a WIDTH-bit word; never below one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sd_piso_serializer.sv
// sd_piso_serializer
//   Parallel-in/serial-out stage feeding the serial 'signal' input of the
//   sequence-detector FSMs. Words are taken over a valid/ready handshake and
//   sent one bit per clock; back-to-back words stream without an idle bubble.
//   All serial outputs are registered so the detector sees a clean bit stream.
//
//   Optional feature: define SD_SER_PARITY_EN to append an even-parity bit
//   (XOR of the accepted word) to every frame.
//
// Parameters
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  1: in_data[WIDTH-1] sent first, 0: in_data[0] sent first
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous, active-low reset
//   in_data    parallel word, sampled when accepted
//   in_valid   upstream word available
//   in_ready   word can be accepted this cycle (combinational, 0 in reset)
//   ser_bit    serial data bit, 0 whenever ser_valid is 0
//   ser_valid  ser_bit carries a frame bit this cycle
//   word_done  one-cycle pulse on the final bit of each frame
module sd_piso_serializer
  import sd_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_ser_bit;
  logic             r_ser_valid;
  logic             r_word_done;
  logic             w_ready;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
`ifdef SD_SER_PARITY_EN
  logic             r_parity;
`endif

  // The word stays whole in r_shift; the bit on the wire is always the
  // output-end bit of the freshly shifted value, so r_ser_bit can be loaded
  // straight from in_data on accept and the first bit leaves one cycle later.
  assign w_shift_next = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
  assign w_first_bit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign w_next_bit   = MSB_FIRST ? w_shift_next[WIDTH-1] : w_shift_next[0];

  assign w_accept  = in_valid && w_ready;
  assign in_ready  = w_ready;
  assign ser_bit   = r_ser_bit;
  assign ser_valid = r_ser_valid;
  assign word_done = r_word_done;

  // Next-state and ready decode. Ready is offered on the cycle that shows the
  // final frame bit so a new word follows with no gap; reset forces it low.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (in_valid) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_bit_cnt == '0) begin
`ifdef SD_SER_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_ready      = 1'b1;
          w_state_next = in_valid ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef SD_SER_PARITY_EN
      ST_PARITY: begin
        w_ready      = 1'b1;
        w_state_next = in_valid ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
    if (!rst) begin
      w_ready      = 1'b0;
      w_state_next = ST_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Datapath: shift register, remaining-bit counter and registered outputs.
  // A reset discards any frame in flight; nothing resumes afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_ser_bit   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_word_done <= 1'b0;
`ifdef SD_SER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_word_done <= 1'b0;
      if (w_accept) begin
        r_shift     <= in_data;
        r_bit_cnt   <= CNT_LOAD;
        r_ser_bit   <= w_first_bit;
        r_ser_valid <= 1'b1;
`ifdef SD_SER_PARITY_EN
        r_parity    <= ^in_data;
`endif
      end else if (r_state == ST_SHIFT && r_bit_cnt != '0) begin
        r_shift     <= w_shift_next;
        r_bit_cnt   <= r_bit_cnt - CNT_ONE;
        r_ser_bit   <= w_next_bit;
        r_ser_valid <= 1'b1;
`ifndef SD_SER_PARITY_EN
        if (r_bit_cnt == CNT_ONE) r_word_done <= 1'b1;
`endif
`ifdef SD_SER_PARITY_EN
      end else if (r_state == ST_SHIFT) begin
        r_ser_bit   <= r_parity;
        r_ser_valid <= 1'b1;
        r_word_done <= 1'b1;
`endif
      end else begin
        r_ser_bit   <= 1'b0;
        r_ser_valid <= 1'b0;
      end
    end
  end

endmodule
